// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
//   Shared definitions for the cnt_timer block.
//   - CNT_WIDTH_DEF / CNT_DIV_DEF : default count width and prescaler ratio
//   - cnt_state_e                 : counter sequencing state (running / done)
//   - clog2                       : ceiling log2, used to size the prescaler
// -----------------------------------------------------------------------------
package cnt_pkg;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int CNT_DIV_DEF   = 1;

  // ST_DONE is the one-shot "stopped at top" state; it is left only when
  // start drops, which re-arms the counter.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage : cnt_pkg

// File: rtl/cnt_if.sv
// -----------------------------------------------------------------------------
// cnt_if
//   Control/status bundle between a controller and cnt_timer.
//   Signals (all level-sensitive, sampled on the rising edge of clk; there is
//   no valid/ready handshake -- start enables counting for as long as it is
//   high, clr_it is an active-low level clear):
//     top     : terminal count, inclusive           (controller -> timer)
//     start   : 1 = count, 0 = pause / re-arm        (controller -> timer)
//     freerun : 1 = wrap at top, 0 = one-shot        (controller -> timer)
//     clr_it  : active-low synchronous clear of it   (controller -> timer)
//     cnt     : current count, registered            (timer -> controller)
//     it      : sticky terminal event, registered    (timer -> controller)
//     state   : sequencing state, debug visibility   (timer -> controller)
//   Modports: master = controller side, slave = timer side.
// -----------------------------------------------------------------------------
interface cnt_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) ();

  logic [WIDTH-1:0] top;
  logic             start;
  logic             freerun;
  logic             clr_it;
  logic [WIDTH-1:0] cnt;
  logic             it;
  cnt_state_e       state;

  modport master (
    output top,
    output start,
    output freerun,
    output clr_it,
    input  cnt,
    input  it,
    input  state
  );

  modport slave (
    input  top,
    input  start,
    input  freerun,
    input  clr_it,
    output cnt,
    output it,
    output state
  );

endinterface : cnt_if

// File: rtl/cnt_prescaler.sv
// -----------------------------------------------------------------------------
// cnt_prescaler
//   Divides the clock into a one-cycle tick every DIV cycles while en is high.
//   The internal counter runs 0..DIV-1, ticks on DIV-1 and is held at 0 while
//   en is low, so the first tick after enabling arrives DIV clocks later.
//   Ports:
//     clk  : clock, rising edge
//     rstn : asynchronous active-low reset
//     en   : enable; low clears the divider
//     tick : one-clock pulse every DIV clocks while en = 1
// -----------------------------------------------------------------------------
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int DIV = CNT_DIV_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  // DIV = 1 needs no counting bits, but keep one so the vector is legal.
  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!en) begin
      pc_d = '0;
    end else if (pc_q == LAST) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign tick = en && (pc_q == LAST);

endmodule : cnt_prescaler

// File: rtl/cnt_timer.sv
// -----------------------------------------------------------------------------
// cnt_timer
//   Up-counter/timer with an inclusive programmable terminal value, free-run
//   or one-shot operation and a sticky terminal-count event flag.
//   Optional feature: define CNT_PRESCALE_EN to advance the count only every
//   DIV clocks (cnt_prescaler); without it the count advances every clock
//   and DIV is ignored.
//   Ports:
//     clk  : clock, rising edge
//     rstn : asynchronous active-low reset (cnt = 0, it = 0, not done)
//     bus  : cnt_if.slave -- top/start/freerun/clr_it in, cnt/it/state out
//   Parameters:
//     WIDTH : count width in bits (must match the interface instance)
//     DIV   : prescaler ratio, >= 1
// -----------------------------------------------------------------------------
module cnt_timer
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF,
  parameter int DIV   = CNT_DIV_DEF
) (
  input  logic   clk,
  input  logic   rstn,
  cnt_if.slave   bus
);

  if (DIV < 1) begin : g_div_check
    $error("cnt_timer: DIV must be >= 1");
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             it_q;
  logic             it_d;
  cnt_state_e       state_q;
  cnt_state_e       state_d;
  logic             tick;
  logic             step;
  logic             terminal;

`ifdef CNT_PRESCALE_EN
  cnt_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.start),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step = bus.start && tick && (state_q == ST_RUN);

  // >= rather than == so that lowering top below the current count ends the
  // cycle on the next step instead of running all the way round.
  assign terminal = (cnt_q >= bus.top);

  always_comb begin
    cnt_d   = cnt_q;
    it_d    = it_q;
    state_d = state_q;

    // Clear first; a terminal event below overrides it so none is lost.
    if (!bus.clr_it) it_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (step) begin
          if (terminal) begin
            it_d = 1'b1;
            if (bus.freerun) begin
              cnt_d = '0;
            end else begin
              // One-shot parks at top (clamping if top was lowered below cnt).
              cnt_d   = bus.top;
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        // Only a drop of start re-arms; freerun changes are ignored here.
        if (!bus.start) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      it_q    <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      it_q    <= it_d;
      state_q <= state_d;
    end
  end

  assign bus.cnt   = cnt_q;
  assign bus.it    = it_q;
  assign bus.state = state_q;

endmodule : cnt_timer

// File: tb/tb_cnt_timer.sv
// -----------------------------------------------------------------------------
// tb_cnt_timer
//   Self-checking bench for cnt_timer (WIDTH = 3, DIV = 4). A behavioural
//   model built from the counter's rules tracks cnt / it / done; every clock
//   the model's expectations are queued and compared against the DUT one
//   time unit after the rising edge. Directed constant checks pin the
//   key scenarios for the default (unprescaled) build.
// -----------------------------------------------------------------------------
module tb_cnt_timer;
  import cnt_pkg::*;

  localparam int W   = 3;
  localparam int DIV = 4;
  localparam int MOD = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cnt_if #(.WIDTH(W)) bus ();

  cnt_timer #(
    .WIDTH (W),
    .DIV   (DIV)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_it_q[$];
  logic         exp_done_q[$];

  // ---------------- reference model ----------------
  int m_cnt;
  int m_it;
  int m_done;
  int m_pre;

  function automatic void model_reset();
    m_cnt  = 0;
    m_it   = 0;
    m_done = 0;
    m_pre  = 0;
  endfunction

  // One rising edge worth of behaviour, from the inputs the DUT just sampled.
  function automatic void model_step();
    int tk;
    int st;
    int tp;
    int nit;
    if (!rstn) begin
      model_reset();
      return;
    end
    st = int'(bus.start);
    tp = int'(bus.top) % MOD;
`ifdef CNT_PRESCALE_EN
    tk    = (st == 1 && m_pre == DIV - 1) ? 1 : 0;
    m_pre = (st == 0) ? 0 : (m_pre + 1) % DIV;
`else
    tk = 1;
`endif
    nit = (bus.clr_it == 1'b0) ? 0 : m_it;
    if (st == 1 && tk == 1 && m_done == 0) begin
      if (m_cnt >= tp) begin
        nit = 1;
        if (bus.freerun) m_cnt = 0;
        else begin
          m_cnt  = tp;
          m_done = 1;
        end
      end else begin
        m_cnt = (m_cnt + 1) % MOD;
      end
    end else if (m_done == 1 && st == 0) begin
      m_cnt  = 0;
      m_done = 0;
    end
    m_it = nit;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic fr, input int tp, input logic clr);
    bus.start   = s;
    bus.freerun = fr;
    bus.top     = W'(tp);
    bus.clr_it  = clr;
  endtask

  // Advance one clock, update the model, compare; returns at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    exp_q.push_back(W'(m_cnt));
    exp_it_q.push_back(m_it[0]);
    exp_done_q.push_back(m_done[0]);
    #1;
    check({tag, "_cnt"},  32'(bus.cnt), 32'(exp_q.pop_front()));
    check({tag, "_it"},   32'(bus.it),  32'(exp_it_q.pop_front()));
    check({tag, "_done"}, {31'b0, bus.state == ST_DONE}, 32'(exp_done_q.pop_front()));
    @(negedge clk);
  endtask

  // Asynchronous reset between edges, held across one rising edge.
  task automatic do_reset(input string tag);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check({tag, "_async_cnt"}, 32'(bus.cnt), 32'd0);
    check({tag, "_async_it"},  32'(bus.it),  32'd0);
    cycle({tag, "_hold"});
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int t2_seq[8];
    t2_seq = '{1, 2, 3, 0, 1, 2, 3, 0};

    drive(1'b0, 1'b1, 3, 1'b1);
    model_reset();
    #1;
    check("reset_cnt", 32'(bus.cnt), 32'd0);
    check("reset_it",  32'(bus.it),  32'd0);
    @(negedge clk);
    cycle("reset_hold");
    rstn = 1'b1;

    // T2: free-run wrap at top = 3
    drive(1'b1, 1'b1, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle("t2");
`ifndef CNT_PRESCALE_EN
      check("t2_seq_cnt", 32'(bus.cnt), 32'(t2_seq[i]));
      check("t2_seq_it",  32'(bus.it),  (i >= 3) ? 32'd1 : 32'd0);
`endif
    end

    // T1: reset mid-count, held two edges, then counting resumes
    cycle("t1_pre");
    cycle("t1_pre");
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("t1_async_cnt", 32'(bus.cnt), 32'd0);
    check("t1_async_it",  32'(bus.it),  32'd0);
    cycle("t1_hold");
    cycle("t1_hold");
    rstn = 1'b1;
    cycle("t1_resume");
`ifndef CNT_PRESCALE_EN
    check("t1_resume_cnt", 32'(bus.cnt), 32'd1);
`endif

    // T4: clear on the same edge as the wrap -> set wins
    for (int i = 0; i < 40 && m_cnt != 3; i++) cycle("t4_run");
    drive(1'b1, 1'b1, 3, 1'b0);
    cycle("t4_race");
`ifndef CNT_PRESCALE_EN
    check("t4_race_it",  32'(bus.it),  32'd1);
    check("t4_race_cnt", 32'(bus.cnt), 32'd0);
`endif
    cycle("t4_clear");
`ifndef CNT_PRESCALE_EN
    check("t4_clear_it", 32'(bus.it), 32'd0);
`endif
    drive(1'b1, 1'b1, 3, 1'b1);

    // T3: one-shot stop at top, re-arm, run again
    do_reset("t3_rst");
    drive(1'b1, 1'b0, 5, 1'b1);
    for (int i = 0; i < 8; i++) cycle("t3_run");
`ifndef CNT_PRESCALE_EN
    check("t3_stop_cnt", 32'(bus.cnt), 32'd5);
    check("t3_stop_it",  32'(bus.it),  32'd1);
`endif
    drive(1'b0, 1'b0, 5, 1'b1);
    cycle("t3_rearm");
    check("t3_rearm_cnt", 32'(bus.cnt), 32'd0);
    drive(1'b1, 1'b0, 5, 1'b1);
    for (int i = 0; i < 6; i++) cycle("t3_again");
`ifndef CNT_PRESCALE_EN
    check("t3_again_cnt", 32'(bus.cnt), 32'd5);
`endif
    // freerun raised while done: stays stopped until start drops
    drive(1'b1, 1'b1, 5, 1'b1);
    for (int i = 0; i < 3; i++) cycle("t3_frtoggle");
`ifndef CNT_PRESCALE_EN
    check("t3_frtoggle_cnt", 32'(bus.cnt), 32'd5);
`endif
    drive(1'b0, 1'b1, 5, 1'b1);
    cycle("t3_frrearm");

    // T5: pause, then lower top below cnt
    do_reset("t5_rst");
    drive(1'b1, 1'b1, 5, 1'b1);
    cycle("t5_run");
    cycle("t5_run");
    drive(1'b0, 1'b1, 5, 1'b1);
    for (int i = 0; i < 4; i++) cycle("t5_pause");
`ifndef CNT_PRESCALE_EN
    check("t5_pause_cnt", 32'(bus.cnt), 32'd2);
`endif
    drive(1'b1, 1'b1, 1, 1'b1);
    cycle("t5_lower");
`ifndef CNT_PRESCALE_EN
    check("t5_lower_cnt", 32'(bus.cnt), 32'd0);
    check("t5_lower_it",  32'(bus.it),  32'd1);
`endif

    // top = 0 free-run: cnt stays 0, it set on every step even with clr_it=0
    drive(1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("top0");
    drive(1'b1, 1'b1, 0, 1'b0);
    cycle("top0_clr");
`ifndef CNT_PRESCALE_EN
    check("top0_cnt", 32'(bus.cnt), 32'd0);
    check("top0_it",  32'(bus.it),  32'd1);
`endif

`ifdef CNT_PRESCALE_EN
    // T6: prescaled count, wrap after 16 clocks
    do_reset("t6_rst");
    drive(1'b1, 1'b1, 3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle("t6");
      if (i == 14) check("t6_pre_wrap_cnt", 32'(bus.cnt), 32'd3);
    end
    check("t6_wrap_cnt", 32'(bus.cnt), 32'd0);
    check("t6_wrap_it",  32'(bus.it),  32'd1);
`endif

    // Randomized stretch against the model
    drive(1'b1, 1'b1, 4, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        bus.start   = ($urandom_range(0, 9) < 8);
        bus.clr_it  = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) bus.freerun = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0)  bus.top = W'($urandom_range(0, MOD - 1));
        cycle("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_cnt_timer
